// File: rtl/sw_seq_ctrl.sv
// sw_seq_ctrl: job sequencer for the Smith-Waterman systolic array
// Ports:
//   clk, reset                  falling-edge clock, asynchronous active-high reset
//   start, s_len, t_len         job request and lengths, sampled only in IDLE
//   in_valid, in_ready, in_data shared symbol stream: query symbols first, then target
//   s_valid, s_data             load strobe and symbol for the query ring
//   t_valid, t_data             target symbol into PE 0
//   pe_en, pe_clear             PE chain step and clear
//   pe_score                    per-step max cell score from the array
//   busy, done, err             status; done and err are one-cycle pulses
//   max_score                   best score of the last completed job
module sw_seq_ctrl #(
    parameter int REG_NUM = 128,
    parameter int T_MAX_W = 10,
    parameter int SCORE_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         s_len,
    input  logic [T_MAX_W-1:0] t_len,
    input  logic               in_valid,
    input  logic [1:0]         in_data,
    output logic               in_ready,
    output logic               s_valid,
    output logic [1:0]         s_data,
    output logic               t_valid,
    output logic [1:0]         t_data,
    output logic               pe_en,
    output logic               pe_clear,
    input  logic [SCORE_W-1:0] pe_score,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SCORE_W-1:0] max_score
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD_S, RUN, DRAIN, DONE} state_t;
    localparam logic [8:0] S_MAX = 9'(REG_NUM);
    localparam logic [T_MAX_W-1:0] ONE = T_MAX_W'(1);
    state_t state, nstate;
    logic [T_MAX_W-1:0] cnt, cnt_d, cnt_inc, s_lim, t_lim;
    logic [7:0] s_len_q;
    logic acc, bad;
    logic s_valid_d, t_valid_d, pe_en_d, pe_clear_d, busy_d, done_d, err_d;
    logic [1:0] s_data_d, t_data_d;
    logic [SCORE_W-1:0] max_d;

    assign in_ready = state == LOAD_S || state == RUN;
    assign acc = in_valid && in_ready;
    assign bad = s_len == 8'd0 || {1'b0, s_len} > S_MAX || t_len == '0;
    assign cnt_inc = cnt + ONE;
    assign s_lim = T_MAX_W'(s_len_q);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            s_len_q <= '0;
            t_lim <= '0;
            s_valid <= 1'b0;
            s_data <= 2'b00;
            t_valid <= 1'b0;
            t_data <= 2'b00;
            pe_en <= 1'b0;
            pe_clear <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            max_score <= '0;
        end else begin
            state <= nstate;
            cnt <= cnt_d;
            if (state == IDLE && nstate == CLEAR) begin
                s_len_q <= s_len;
                t_lim <= t_len;
            end
            s_valid <= s_valid_d;
            s_data <= s_data_d;
            t_valid <= t_valid_d;
            t_data <= t_data_d;
            pe_en <= pe_en_d;
            pe_clear <= pe_clear_d;
            busy <= busy_d;
            done <= done_d;
            err <= err_d;
            max_score <= max_d;
        end
    end

    // Drain runs s_len-1 steps so the last target symbol reaches the last PE.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start && !bad) nstate = CLEAR;
            CLEAR:   nstate = LOAD_S;
            LOAD_S:  if (acc && cnt_inc == s_lim) nstate = RUN;
            RUN:     if (acc && cnt_inc == t_lim) nstate = s_len_q == 8'd1 ? DONE : DRAIN;
            DRAIN:   if (cnt_inc == s_lim - ONE) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // The counter restarts on every state change; it counts accepts, or drain steps in DRAIN.
    always_comb begin
        cnt_d = nstate != state ? '0 : (acc || state == DRAIN) ? cnt_inc : cnt;
        s_valid_d = acc && state == LOAD_S;
        s_data_d = s_valid_d ? in_data : 2'b00;
        t_valid_d = acc && state == RUN;
        t_data_d = t_valid_d ? in_data : 2'b00;
        pe_en_d = t_valid_d || state == DRAIN;
        pe_clear_d = nstate == CLEAR;
        busy_d = nstate != IDLE;
        done_d = state == DONE;
        err_d = state == IDLE && start && bad;
        max_d = pe_clear_d ? '0 : (pe_en && pe_score > max_score) ? pe_score : max_score;
    end
endmodule

// File: tb/tb_sw_seq_ctrl.sv
// tb_sw_seq_ctrl: randomized self-checking bench for sw_seq_ctrl against a job-level reference model
module tb_sw_seq_ctrl;
    localparam int T_MAX_W = 10;
    localparam int SCORE_W = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] s_len = '0;
    logic [T_MAX_W-1:0] t_len = '0;
    logic in_valid = 1'b0;
    logic [1:0] in_data = '0;
    logic in_ready, s_valid, t_valid, pe_en, pe_clear, busy, done, err;
    logic [1:0] s_data, t_data;
    logic [SCORE_W-1:0] pe_score = '0;
    logic [SCORE_W-1:0] max_score;

    int checks = 0;
    int errors = 0;

    // job stimulus
    logic [1:0] q_sym[$];
    logic [1:0] t_sym[$];
    int score_list[$];
    // job observations and model results
    logic [1:0] s_obs[$];
    logic [1:0] t_obs[$];
    int clear_cnt, clear_late, pe_cnt, drain_cnt, tv_no_pe, drain_data;
    int done_cnt, done_cyc, last_pe, err_cnt, extra_acc, s_diff, t_diff, timed_out;
    logic [SCORE_W-1:0] exp_max, max_at_done, max_first, post_max;
    logic post_busy, post_done;

    sw_seq_ctrl #(.REG_NUM(128), .T_MAX_W(T_MAX_W), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .reset(reset), .start(start), .s_len(s_len), .t_len(t_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .s_valid(s_valid), .s_data(s_data), .t_valid(t_valid), .t_data(t_data),
        .pe_en(pe_en), .pe_clear(pe_clear), .pe_score(pe_score),
        .busy(busy), .done(done), .err(err), .max_score(max_score)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic rand_syms(input int sl, input int tl);
        q_sym.delete();
        t_sym.delete();
        for (int i = 0; i < sl; i++) q_sym.push_back(2'($urandom));
        for (int i = 0; i < tl; i++) t_sym.push_back(2'($urandom));
    endtask

    // Drives one job (mode 0: valid held high, 1: target valid toggling, 2: random valid
    // plus stray starts) and records what the DUT emits. Outputs are sampled on posedge,
    // opposite to the DUT's falling active edge.
    task automatic run_job(input int sl, input int tl, input int mode);
        logic [1:0] syms[$];
        int idx, cyc;
        bit seen, tog;
        logic [SCORE_W-1:0] sc;
        syms.delete();
        foreach (q_sym[i]) syms.push_back(q_sym[i]);
        foreach (t_sym[i]) syms.push_back(t_sym[i]);
        s_obs.delete();
        t_obs.delete();
        clear_cnt = 0; clear_late = 0; pe_cnt = 0; drain_cnt = 0; tv_no_pe = 0; drain_data = 0;
        done_cnt = 0; done_cyc = -1; last_pe = -100; err_cnt = 0; extra_acc = 0;
        exp_max = '0; max_at_done = '0; max_first = '1;
        seen = 0; idx = 0; cyc = 0; tog = 1;
        @(posedge clk);
        start = 1'b1; s_len = 8'(sl); t_len = T_MAX_W'(tl);
        while (!seen && cyc < 3000) begin
            @(posedge clk);
            if (cyc == 0) max_first = max_score;
            if (pe_clear) begin
                clear_cnt++;
                if (s_obs.size() != 0) clear_late++;
            end
            if (s_valid) s_obs.push_back(s_data);
            if (t_valid) begin
                t_obs.push_back(t_data);
                if (!pe_en) tv_no_pe++;
            end
            if (pe_en) begin
                sc = pe_cnt < score_list.size() ? SCORE_W'(score_list[pe_cnt]) : SCORE_W'($urandom);
                pe_cnt++;
                last_pe = cyc;
                if (!t_valid) begin
                    drain_cnt++;
                    if (t_data != 2'b00) drain_data++;
                end
                if (sc > exp_max) exp_max = sc;
            end else sc = SCORE_W'($urandom);
            pe_score = sc;
            if (done) begin
                seen = 1;
                done_cnt++;
                done_cyc = cyc;
                max_at_done = max_score;
            end
            if (err) err_cnt++;
            start = mode == 2 && !seen && $urandom_range(0, 7) == 0;
            if (start) begin
                s_len = 8'($urandom);
                t_len = T_MAX_W'($urandom_range(0, 3));
            end
            if (idx < syms.size()) begin
                in_valid = mode == 0 ? 1'b1 : mode == 1 ? (idx < sl ? 1'b1 : tog) : ($urandom_range(0, 3) != 0);
                in_data = syms[idx];
            end else begin
                in_valid = 1'b1;
                in_data = 2'($urandom);
            end
            tog = !tog;
            if (in_valid && in_ready) begin
                if (idx < syms.size()) idx++;
                else extra_acc++;
            end
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        timed_out = seen ? 0 : 1;
        @(posedge clk);
        post_busy = busy;
        post_max = max_score;
        post_done = done;
        s_diff = s_obs.size() == q_sym.size() ? 0 : 1;
        foreach (q_sym[i]) if (i < s_obs.size() && s_obs[i] != q_sym[i]) s_diff++;
        t_diff = t_obs.size() == t_sym.size() ? 0 : 1;
        foreach (t_sym[i]) if (i < t_obs.size() && t_obs[i] != t_sym[i]) t_diff++;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        repeat (2) @(posedge clk);
        outs = {busy, in_ready, done, err, pe_en, pe_clear, s_valid, t_valid};
        checks++; if (outs !== 8'h00) begin errors++; $display("FAIL reset outputs: got %b expected 00000000", outs); end
        checks++; if (max_score !== '0) begin errors++; $display("FAIL reset max_score: got %0d expected 0", max_score); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        outs = {busy, in_ready, done, err, pe_en, pe_clear, s_valid, t_valid};
        checks++; if (outs !== 8'h00) begin errors++; $display("FAIL idle outputs: got %b expected 00000000", outs); end
    endtask

    task automatic test_basic();
        q_sym = '{2'd0, 2'd1, 2'd2};
        t_sym = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
        score_list = '{4, 9, 2, 9, 1, 0, 5};
        run_job(3, 5, 0);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL basic timeout: got %0d expected 0", timed_out); end
        checks++; if (clear_cnt !== 1) begin errors++; $display("FAIL basic pe_clear cycles: got %0d expected 1", clear_cnt); end
        checks++; if (clear_late !== 0) begin errors++; $display("FAIL basic pe_clear after load: got %0d expected 0", clear_late); end
        checks++; if (s_diff !== 0) begin errors++; $display("FAIL basic query strobes: got %0d diffs (%0d strobes) expected 0 (3)", s_diff, s_obs.size()); end
        checks++; if (t_diff !== 0) begin errors++; $display("FAIL basic target strobes: got %0d diffs (%0d strobes) expected 0 (5)", t_diff, t_obs.size()); end
        checks++; if (pe_cnt !== 7) begin errors++; $display("FAIL basic pe_en count: got %0d expected 7", pe_cnt); end
        checks++; if (drain_cnt !== 2) begin errors++; $display("FAIL basic drain cycles: got %0d expected 2", drain_cnt); end
        checks++; if (drain_data !== 0) begin errors++; $display("FAIL basic drain t_data: got %0d nonzero expected 0", drain_data); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic done pulses: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc !== last_pe + 1) begin errors++; $display("FAIL basic done timing: got cycle %0d expected %0d", done_cyc, last_pe + 1); end
        checks++; if (max_at_done !== 12'd9) begin errors++; $display("FAIL basic max_score: got %0d expected 9", max_at_done); end
        checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL basic after done busy/done: got %b%b expected 00", post_busy, post_done); end
        checks++; if (extra_acc !== 0 || err_cnt !== 0) begin errors++; $display("FAIL basic extra accepts/err: got %0d/%0d expected 0/0", extra_acc, err_cnt); end
    endtask

    task automatic test_stall();
        q_sym = '{2'd0, 2'd1, 2'd2};
        t_sym = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
        score_list.delete();
        run_job(3, 5, 1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL stall timeout: got %0d expected 0", timed_out); end
        checks++; if (t_diff !== 0 || s_diff !== 0) begin errors++; $display("FAIL stall data order: got %0d/%0d diffs expected 0/0", s_diff, t_diff); end
        checks++; if (pe_cnt !== 7) begin errors++; $display("FAIL stall pe_en count: got %0d expected 7", pe_cnt); end
        checks++; if (drain_cnt !== 2) begin errors++; $display("FAIL stall pe_en without target: got %0d expected 2", drain_cnt); end
        checks++; if (tv_no_pe !== 0) begin errors++; $display("FAIL stall t_valid without pe_en: got %0d expected 0", tv_no_pe); end
        checks++; if (max_at_done !== exp_max) begin errors++; $display("FAIL stall max_score: got %0d expected %0d", max_at_done, exp_max); end
    endtask

    task automatic test_score_clear();
        q_sym = '{2'd2, 2'd1, 2'd0};
        t_sym = '{2'd1, 2'd0, 2'd3, 2'd3, 2'd2};
        score_list = '{4, 9, 2, 9, 1, 0, 5};
        run_job(3, 5, 0);
        repeat (6) @(posedge clk);
        checks++; if (max_score !== 12'd9) begin errors++; $display("FAIL score hold in idle: got %0d expected 9", max_score); end
        rand_syms(1, 1);
        score_list.delete();
        run_job(1, 1, 0);
        checks++; if (max_first !== '0) begin errors++; $display("FAIL score cleared at start: got %0d expected 0", max_first); end
        checks++; if (max_at_done !== exp_max) begin errors++; $display("FAIL score next job: got %0d expected %0d", max_at_done, exp_max); end
        checks++; if (post_max !== exp_max) begin errors++; $display("FAIL score held after done: got %0d expected %0d", post_max, exp_max); end
    endtask

    task automatic test_reject();
        int sls[3] = '{0, 129, 3};
        int tls[3] = '{5, 5, 0};
        int n_err;
        bit any_busy;
        for (int c = 0; c < 3; c++) begin
            n_err = 0;
            any_busy = 0;
            @(posedge clk);
            start = 1'b1; s_len = 8'(sls[c]); t_len = T_MAX_W'(tls[c]);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                start = 1'b0;
                if (err) n_err++;
                if (busy || in_ready) any_busy = 1;
            end
            checks++; if (n_err !== 1) begin errors++; $display("FAIL reject s_len=%0d t_len=%0d err pulses: got %0d expected 1", sls[c], tls[c], n_err); end
            checks++; if (any_busy !== 0) begin errors++; $display("FAIL reject s_len=%0d t_len=%0d busy: got %0d expected 0", sls[c], tls[c], any_busy); end
        end
    endtask

    task automatic test_min();
        rand_syms(1, 1);
        score_list.delete();
        run_job(1, 1, 0);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL min timeout: got %0d expected 0", timed_out); end
        checks++; if (s_diff !== 0 || t_diff !== 0) begin errors++; $display("FAIL min strobes: got %0d/%0d diffs expected 0/0", s_diff, t_diff); end
        checks++; if (pe_cnt !== 1 || drain_cnt !== 0) begin errors++; $display("FAIL min pe_en/drain: got %0d/%0d expected 1/0", pe_cnt, drain_cnt); end
        checks++; if (done_cyc !== last_pe + 1) begin errors++; $display("FAIL min done timing: got cycle %0d expected %0d", done_cyc, last_pe + 1); end
    endtask

    task automatic test_boundary();
        rand_syms(128, 2);
        score_list.delete();
        run_job(128, 2, 0);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL max query timeout: got %0d expected 0", timed_out); end
        checks++; if (s_diff !== 0 || t_diff !== 0) begin errors++; $display("FAIL max query strobes: got %0d/%0d diffs expected 0/0", s_diff, t_diff); end
        checks++; if (pe_cnt !== 129 || drain_cnt !== 127) begin errors++; $display("FAIL max query pe_en/drain: got %0d/%0d expected 129/127", pe_cnt, drain_cnt); end
        checks++; if (max_at_done !== exp_max) begin errors++; $display("FAIL max query score: got %0d expected %0d", max_at_done, exp_max); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] outs;
        n = 0;
        @(posedge clk);
        start = 1'b1; s_len = 8'd4; t_len = T_MAX_W'(20);
        @(posedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        while (!t_valid && n < 200) begin
            in_data = 2'($urandom);
            pe_score = SCORE_W'($urandom_range(1, 4095));
            @(posedge clk);
            n++;
        end
        checks++; if (t_valid !== 1'b1) begin errors++; $display("FAIL reset-mid reach RUN: got t_valid %b expected 1", t_valid); end
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        outs = {busy, in_ready, done, err, pe_en, pe_clear, s_valid, t_valid};
        checks++; if (outs !== 8'h00 || max_score !== '0) begin errors++; $display("FAIL reset-mid outputs: got %b max %0d expected 00000000 max 0", outs, max_score); end
        #1 reset = 1'b0;
        in_valid = 1'b0;
        rand_syms(2, 3);
        score_list.delete();
        run_job(2, 3, 0);
        checks++; if (timed_out !== 0 || done_cnt !== 1) begin errors++; $display("FAIL reset-mid next job done: got timeout %0d pulses %0d expected 0 1", timed_out, done_cnt); end
        checks++; if (s_diff !== 0 || t_diff !== 0) begin errors++; $display("FAIL reset-mid next job strobes: got %0d/%0d diffs expected 0/0", s_diff, t_diff); end
        checks++; if (pe_cnt !== 4) begin errors++; $display("FAIL reset-mid next job pe_en: got %0d expected 4", pe_cnt); end
        checks++; if (max_at_done !== exp_max) begin errors++; $display("FAIL reset-mid next job score: got %0d expected %0d", max_at_done, exp_max); end
    endtask

    task automatic test_random();
        int sl, tl;
        score_list.delete();
        for (int j = 0; j < 8; j++) begin
            sl = $urandom_range(1, 24);
            tl = $urandom_range(1, 40);
            rand_syms(sl, tl);
            run_job(sl, tl, 2);
            checks++; if (timed_out !== 0 || done_cnt !== 1) begin errors++; $display("FAIL random job %0d done: got timeout %0d pulses %0d expected 0 1", j, timed_out, done_cnt); end
            checks++; if (s_diff !== 0 || t_diff !== 0) begin errors++; $display("FAIL random job %0d strobes: got %0d/%0d diffs expected 0/0", j, s_diff, t_diff); end
            checks++; if (pe_cnt !== tl + sl - 1) begin errors++; $display("FAIL random job %0d pe_en: got %0d expected %0d", j, pe_cnt, tl + sl - 1); end
            checks++; if (drain_cnt !== sl - 1) begin errors++; $display("FAIL random job %0d drain: got %0d expected %0d", j, drain_cnt, sl - 1); end
            checks++; if (max_at_done !== exp_max) begin errors++; $display("FAIL random job %0d score: got %0d expected %0d", j, max_at_done, exp_max); end
            checks++; if (err_cnt !== 0 || extra_acc !== 0 || tv_no_pe !== 0) begin errors++; $display("FAIL random job %0d err/extra/tv: got %0d/%0d/%0d expected 0/0/0", j, err_cnt, extra_acc, tv_no_pe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_score_clear();
        test_reject();
        test_min();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sw_seq_ctrl.md
Name: sw_seq_ctrl

Overview:
- Sequencer for the Smith-Waterman systolic datapath.
- Takes one shared 2-bit symbol stream with a valid/ready handshake: the query first, then the target.
- Loads the query into the recirculating query register ring, streams the target into the PE chain, then drains the array.
- Tracks the running maximum PE score and reports it with a done pulse.

Parameters:
- REG_NUM, 128, query ring depth (maximum query length).
- T_MAX_W, 10, width of the target length field (max target 1023).
- SCORE_W, 12, width of the PE score and max_score (unsigned).

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the array.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- s_len  in  8  query length; latched at start.
- t_len  in  T_MAX_W  target length; latched at start.
- in_valid  in  1  symbol available on in_data.
- in_data  in  2  nucleotide symbol.
- in_ready  out  1  controller accepts a symbol this cycle.
- s_valid  out  1  load strobe to the query ring; selects s_data over recirculation.
- s_data  out  2  query symbol to the ring.
- t_valid  out  1  target symbol valid into PE 0.
- t_data  out  2  target symbol into PE 0.
- pe_en  out  1  advance the PE chain by one step.
- pe_clear  out  1  clear PE H/E/F registers.
- pe_score  in  SCORE_W  max cell score from the PE array for the current step.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse when a start is rejected.
- max_score  out  SCORE_W  best score of the last completed job.

Behaviour:
- Reset: state=IDLE; all outputs 0, including max_score; all counters 0.
- States: IDLE, CLEAR, LOAD_S, RUN, DRAIN, DONE.
- Handshake: a symbol is accepted on a clock edge where in_valid and in_ready are both 1.
- in_ready is combinational: 1 only in LOAD_S and RUN.
- All other outputs are registered.
- s_valid, s_data, t_valid, t_data and pe_en assert one edge after acceptance, for exactly one cycle per accepted symbol.
- IDLE, start=1:
  - If s_len==0, s_len>REG_NUM or t_len==0: pulse err, stay in IDLE.
  - Otherwise latch both lengths and go to CLEAR.
- IDLE: start=0 ignored. start is ignored in every state other than IDLE.
- CLEAR: pe_clear=1 for exactly 1 cycle; max_score <= 0; go to LOAD_S.
- LOAD_S:
  - Each accepted symbol produces s_valid=1 with s_data=in_data.
  - Stay until s_len symbols are accepted, then go to RUN.
  - The last query accept and the first target accept cannot occur in the same cycle.
- RUN:
  - Each accepted symbol produces t_valid=1, t_data=in_data and pe_en=1.
  - Cycles with in_valid=0 give pe_en=0 and t_valid=0 (array stalls; no bubble enters).
  - After t_len accepts, go to DRAIN.
- DRAIN:
  - pe_en=1, t_valid=0, t_data=0, in_ready=0 for exactly s_len-1 cycles. Zero cycles when s_len==1; then go straight to DONE.
  - Exactly s_len-1 drain cycles must be counted whatever the symbol stream does.
- Score tracking:
  - On every cycle where the registered pe_en==1, max_score <= max(max_score, pe_score), unsigned compare.
  - This includes the cycle after the last drain step.
- DONE: done=1 for 1 cycle; max_score is final and holds until the next CLEAR; go to IDLE.
- Counters:
  - Accept counter is T_MAX_W bits wide and resets to 0 on each state entry.
  - Compare is equality with the latched length; no wrap is possible with legal lengths.
- Reset mid-job: immediate return to IDLE with all outputs 0. The ring and PE contents are not guaranteed; the next job's CLEAR and LOAD_S re-establish them.
- Total pe_en cycles per job = t_len + s_len - 1.

Test Plan:
- Reset → busy=0, in_ready=0, max_score=0, done=0, no pulses.
- start with s_len=3, t_len=5, in_valid held 1, symbols 0,1,2 then 3,3,0,1,2 →
  - pe_clear for 1 cycle; 3 s_valid strobes carrying 0,1,2; 5 t_valid strobes carrying 3,3,0,1,2.
  - 2 drain cycles; pe_en count = 7; done pulse; busy low the next cycle.
- Same job with in_valid toggled 1,0,1,0 during RUN → pe_en appears only on accepted cycles; pe_en total still 7; data order preserved.
- pe_score driven 4,9,2,9,1,0,5 on the pe_en cycles → max_score=9 at done and held through IDLE; the next start clears it to 0.
- Rejected starts:
  - s_len=0 → err pulse, busy stays 0.
  - s_len=129 (REG_NUM=128) → err pulse, busy stays 0.
  - t_len=0 → err pulse, busy stays 0.
- Edge cases:
  - s_len=1, t_len=1 → one s_valid, one t_valid, zero drain cycles, done 2 cycles after the target accept.
  - reset asserted mid-RUN → all outputs 0 asynchronously; a new start then completes normally.
